ptp_timebase: RTL and testbench
===============================

// Module: ptp_timebase
// PURPOSE
// - Free-running PTP time-of-day counter (48-bit seconds, 32-bit nanoseconds) for the 50 MHz domain.
// - Feeds ptp_sec/ptp_ns to the 48 kHz periodic-output generator and the timestampers.
// - Servo software trims the rate through a fractional increment, corrects offset by slewing or
//   stepping, and loads absolute time. Emits a 1-cycle PPS on each natural seconds rollover.
// PARAMETERS
// - CLK_PERIOD_NS   20          reset integer ns increment per clk (50 MHz)
// - SLEW_STEP_NS    4           extra/withheld ns per cycle while slewing; must be < CLK_PERIOD_NS
// - STEP_THRESH_NS  1000000     |offset| >= this is stepped in one cycle; below it is slewed
// PORTS
// - clk          in   1   50 MHz clock, shared with all PTP consumers
// - rst_n        in   1   asynchronous, active-low reset
// - set_valid    in   1   load absolute time (1-cycle strobe)
// - set_sec      in   48  seconds to load
// - set_ns       in   32  nanoseconds to load; values >= 1e9 saturate to 999999999
// - adj_valid    in   1   apply offset correction (1-cycle strobe)
// - adj_neg      in   1   1 = move time backwards
// - adj_ns       in   30  offset magnitude; >= 1e9 saturates to 999999999
// - rate_valid   in   1   load new increment (1-cycle strobe)
// - rate_int     in   8   integer ns per clk
// - rate_frac    in   32  fractional ns per clk (units of 2^-32 ns)
// - ptp_sec      out  48  current seconds
// - ptp_ns       out  32  current nanoseconds, always in 0..999999999
// - pps          out  1   1-cycle pulse on the cycle ptp_sec advances by natural rollover
// - adj_busy     out  1   slew in progress
// BEHAVIOUR
// - Reset: ptp_sec=0, ptp_ns=0, pps=0, adj_busy=0; frac_acc=0, inc_int=CLK_PERIOD_NS,
//   inc_frac=0, slew_rem=0, state IDLE.
// - Every cycle: {carry,frac_acc} = frac_acc + inc_frac; delta = inc_int + carry (+/- slew term).
//   ptp_ns' = ptp_ns + delta; if >= 1e9 then subtract 1e9, increment ptp_sec, assert pps next cycle.
//   At most one wrap per cycle. ptp_sec wraps 2^48-1 -> 0; pps fires on that wrap.
// - rate_valid: inc_int/inc_frac are latched; the new increment is first used the following cycle.
//   frac_acc is not cleared. rate_int=0 is legal: time freezes; slew is held off (remainder frozen).
// - set_valid: highest priority. ptp_sec/ptp_ns = set values on the next cycle. frac_acc is cleared,
//   any slew is cancelled (state IDLE, adj_busy=0), and pps is not asserted. Counting resumes the
//   cycle after the load.
// - adj_valid with |adj| >= STEP_THRESH_NS (STEP): one-cycle update
//   ptp_ns' = ptp_ns + delta +/- adj with a single carry into or borrow from ptp_sec.
//   A borrow below sec 0 wraps to 2^48-1. No pps. Any slew in progress is cancelled.
// - adj_valid with |adj| < STEP_THRESH_NS (SLEW): slew_rem = |adj|, state SLEW, and adj_busy=1 on
//   the next cycle. A new adj replaces the remaining amount; it does not accumulate. adj=0 goes IDLE.
// - Each SLEW cycle: s = min(SLEW_STEP_NS, slew_rem). delta += s (forward) or delta -= s (backward);
//   slew_rem -= s. When slew_rem reaches 0: IDLE, adj_busy=0 on the next cycle.
//   Backward slew never makes time decrease, because SLEW_STEP_NS < inc_int is required.
//   If inc_int <= SLEW_STEP_NS, a backward slew cycle is skipped (remainder held).
// - Priority on the same cycle: set > adj. rate_valid is independent and may coincide with either.
// - States: IDLE -> SLEW (small adj); SLEW -> IDLE (rem 0, set, or step); SLEW -> SLEW (new small adj).
// - Arithmetic: ns sum 33 bits. The step path is computed in signed 34 bits before normalization.
//   Outputs are registered with no combinational path from inputs.
// - Reset asserted mid-slew returns every register to its reset value asynchronously.
// STRUCTURE
// - ptp_pkg: NS_PER_SEC=1_000_000_000, PTP_SEC_W=48, PTP_NS_W=32, PTP_FRAC_W=32, state enum
//   {IDLE,SLEW}. Shared with the periodic-output generator and the timestampers.
// - Sub-module ptp_ns_normalize (combinational): takes a signed ns sum and sec, and returns a
//   normalized {sec,ns} plus a carry flag. It is used by both the tick path and the step path.
// TESTING
// - Reset, default rate: after 50,000,000 cycles -> ptp_sec=1, ptp_ns=0, exactly one pps, on that cycle.
// - rate_int=19, rate_frac=0x8000_0000 -> ptp_ns advances 19,20,19,20...;
//   after 1000 cycles it has advanced exactly 19500.
// - set sec=5, ns=999999990 -> next cycle 5/999999990; next 6/10 with pps=1.
//   set with ns=1.2e9 -> ns=999999999.
// - adj_neg=1, adj_ns=10 at default rate -> adj_busy for 3 cycles, deltas 16,16,18, then 20.
//   ptp_ns never decreases.
// - adj_neg=1, adj_ns=5,000,000 at sec=3, ns=1,000 -> next cycle sec=2, ns=995,001,020; no pps.
//   The same at sec=0 -> sec=2^48-1.
// - set_valid and adj_valid on the same cycle during a slew -> set values loaded, adj ignored,
//   adj_busy=0. rate_valid on the same cycle still takes effect.

Source files
------------

// File: rtl/ptp_pkg.sv
// Shared PTP timebase definitions: field widths, ns-per-second and the
// slew FSM state type used by the timebase and its consumers.
package ptp_pkg;

  localparam int unsigned NS_PER_SEC = 1_000_000_000;
  localparam int          PTP_SEC_W  = 48;
  localparam int          PTP_NS_W   = 32;
  localparam int          PTP_FRAC_W = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SLEW = 1'b1
  } ptp_state_e;

endpackage

// File: rtl/ptp_ns_normalize.sv
// Folds a signed nanosecond sum back into 0..NS_PER_SEC-1, moving at most
// one second into or out of the seconds field. Seconds wrap modulo 2^48.
module ptp_ns_normalize
  import ptp_pkg::*;
(
  input  logic signed [33:0]          ns_sum,
  input  logic [PTP_SEC_W-1:0]        sec_in,
  output logic [PTP_SEC_W-1:0]        sec_out,
  output logic [PTP_NS_W-1:0]         ns_out,
  output logic                        carry
);

  localparam logic signed [33:0] NS_S  = 34'(NS_PER_SEC);
  localparam logic [PTP_NS_W-1:0] NS_U = PTP_NS_W'(NS_PER_SEC);

  // single carry or borrow; low 32 bits are exact modulo 2^32
  always_comb begin
    sec_out = sec_in;
    ns_out  = ns_sum[PTP_NS_W-1:0];
    carry   = 1'b0;
    if (ns_sum >= NS_S) begin
      sec_out = sec_in + 48'd1;
      ns_out  = ns_sum[PTP_NS_W-1:0] - NS_U;
      carry   = 1'b1;
    end else if (ns_sum < 34'sd0) begin
      sec_out = sec_in - 48'd1;
      ns_out  = ns_sum[PTP_NS_W-1:0] + NS_U;
    end
  end

endmodule

// File: rtl/ptp_timebase.sv
// Free-running PTP time-of-day counter with fractional rate trim,
// offset slew/step correction, absolute load and PPS on natural rollover.
//
// state | meaning
// IDLE  | no correction pending, time advances by the programmed increment
// SLEW  | slew_rem ns still to be added/withheld, SLEW_STEP_NS per cycle
module ptp_timebase
  import ptp_pkg::*;
#(
  parameter int unsigned CLK_PERIOD_NS  = 20,
  parameter int unsigned SLEW_STEP_NS   = 4,
  parameter int unsigned STEP_THRESH_NS = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_valid,
  input  logic [PTP_SEC_W-1:0]  set_sec,
  input  logic [PTP_NS_W-1:0]   set_ns,
  input  logic                  adj_valid,
  input  logic                  adj_neg,
  input  logic [29:0]           adj_ns,
  input  logic                  rate_valid,
  input  logic [7:0]            rate_int,
  input  logic [PTP_FRAC_W-1:0] rate_frac,
  output logic [PTP_SEC_W-1:0]  ptp_sec,
  output logic [PTP_NS_W-1:0]   ptp_ns,
  output logic                  pps,
  output logic                  adj_busy
);

  localparam logic [7:0]          INC_RST    = 8'(CLK_PERIOD_NS);
  localparam logic [7:0]          SLEW_STEP8 = 8'(SLEW_STEP_NS);
  localparam logic [29:0]         SLEW_STEP  = 30'(SLEW_STEP_NS);
  localparam logic [29:0]         STEP_THR   = 30'(STEP_THRESH_NS);
  localparam logic [29:0]         ADJ_MAX    = 30'd999_999_999;
  localparam logic [PTP_NS_W-1:0] NS_MAX     = 32'd999_999_999;

  ptp_state_e            state;
  logic [PTP_FRAC_W-1:0] frac_acc;
  logic [7:0]            inc_int;
  logic [PTP_FRAC_W-1:0] inc_frac;
  logic [29:0]           slew_rem;
  logic                  slew_neg;

  logic [PTP_FRAC_W:0]   frac_sum;
  logic [29:0]           adj_mag;
  logic                  step_req;
  logic [29:0]           slew_s;
  logic                  slew_en;
  logic signed [33:0]    delta;
  logic signed [33:0]    step_term;
  logic signed [33:0]    ns_sum;
  logic [PTP_SEC_W-1:0]  norm_sec;
  logic [PTP_NS_W-1:0]   norm_ns;
  logic                  norm_carry;

  // per-cycle increment, slew term and optional step offset
  always_comb begin
    frac_sum = {1'b0, frac_acc} + {1'b0, inc_frac};
    adj_mag  = (adj_ns > ADJ_MAX) ? ADJ_MAX : adj_ns;
    step_req = adj_valid && (adj_mag >= STEP_THR);
    slew_s   = (slew_rem < SLEW_STEP) ? slew_rem : SLEW_STEP;
    // a frozen clock holds the slew; a backward slew must never stop or reverse time
    slew_en  = (state == SLEW) && (inc_int != 8'd0) &&
               (!slew_neg || (inc_int > SLEW_STEP8));
    delta    = $signed({26'd0, inc_int}) + $signed({33'd0, frac_sum[PTP_FRAC_W]});
    if (slew_en) begin
      if (slew_neg) delta = delta - $signed({4'd0, slew_s});
      else          delta = delta + $signed({4'd0, slew_s});
    end
    step_term = 34'sd0;
    if (step_req) begin
      if (adj_neg) step_term = -$signed({4'd0, adj_mag});
      else         step_term =  $signed({4'd0, adj_mag});
    end
    ns_sum = $signed({2'b00, ptp_ns}) + delta + step_term;
  end

  ptp_ns_normalize u_norm (
    .ns_sum  (ns_sum),
    .sec_in  (ptp_sec),
    .sec_out (norm_sec),
    .ns_out  (norm_ns),
    .carry   (norm_carry)
  );

  // time-of-day, fractional accumulator and slew FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptp_sec  <= '0;
      ptp_ns   <= '0;
      pps      <= 1'b0;
      frac_acc <= '0;
      slew_rem <= '0;
      slew_neg <= 1'b0;
      state    <= IDLE;
    end else if (set_valid) begin
      ptp_sec  <= set_sec;
      ptp_ns   <= (set_ns > NS_MAX) ? NS_MAX : set_ns;
      pps      <= 1'b0;
      frac_acc <= '0;
      slew_rem <= '0;
      state    <= IDLE;
    end else begin
      ptp_sec  <= norm_sec;
      ptp_ns   <= norm_ns;
      pps      <= norm_carry && !step_req;
      frac_acc <= frac_sum[PTP_FRAC_W-1:0];
      if (adj_valid) begin
        if (step_req || (adj_mag == 30'd0)) begin
          slew_rem <= '0;
          state    <= IDLE;
        end else begin
          slew_rem <= adj_mag;
          slew_neg <= adj_neg;
          state    <= SLEW;
        end
      end else if (slew_en) begin
        slew_rem <= slew_rem - slew_s;
        if (slew_rem == slew_s) state <= IDLE;
      end
    end
  end

  // increment registers; a new rate is first used on the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_int  <= INC_RST;
      inc_frac <= '0;
    end else if (rate_valid) begin
      inc_int  <= rate_int;
      inc_frac <= rate_frac;
    end
  end

  assign adj_busy = (state == SLEW);

endmodule

// File: tb/tb_ptp_timebase.sv
// Directed checks of ptp_timebase: reset, rollover/pps, rate trim, slew,
// step, set/adj priority, seconds wrap, frozen rate and async reset.
module tb_ptp_timebase;

  logic        clk;
  logic        rst_n;
  logic        set_valid;
  logic [47:0] set_sec;
  logic [31:0] set_ns;
  logic        adj_valid;
  logic        adj_neg;
  logic [29:0] adj_ns;
  logic        rate_valid;
  logic [7:0]  rate_int;
  logic [31:0] rate_frac;
  logic [47:0] ptp_sec;
  logic [31:0] ptp_ns;
  logic        pps;
  logic        adj_busy;

  int n_checks = 0;
  int n_pass   = 0;

  ptp_timebase dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_valid  (set_valid),
    .set_sec    (set_sec),
    .set_ns     (set_ns),
    .adj_valid  (adj_valid),
    .adj_neg    (adj_neg),
    .adj_ns     (adj_ns),
    .rate_valid (rate_valid),
    .rate_int   (rate_int),
    .rate_frac  (rate_frac),
    .ptp_sec    (ptp_sec),
    .ptp_ns     (ptp_ns),
    .pps        (pps),
    .adj_busy   (adj_busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_set(input logic [47:0] s, input logic [31:0] ns);
    set_valid = 1'b1; set_sec = s; set_ns = ns;
    step_clk(1);
    set_valid = 1'b0;
  endtask

  task automatic do_adj(input logic neg, input logic [29:0] mag);
    adj_valid = 1'b1; adj_neg = neg; adj_ns = mag;
    step_clk(1);
    adj_valid = 1'b0;
  endtask

  int unsigned slew_delta [4] = '{16, 16, 18, 20};
  logic        slew_busy  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] prev_ns;

  initial begin
    rst_n = 1'b0; set_valid = 1'b0; set_sec = '0; set_ns = '0;
    adj_valid = 1'b0; adj_neg = 1'b0; adj_ns = '0;
    rate_valid = 1'b0; rate_int = '0; rate_frac = '0;
    step_clk(2);
    chk("rst_sec", ptp_sec, 0);
    chk("rst_ns", ptp_ns, 0);
    chk("rst_pps", pps, 0);
    chk("rst_busy", adj_busy, 0);

    rst_n = 1'b1;
    step_clk(3);
    chk("run_ns", ptp_ns, 60);
    chk("run_sec", ptp_sec, 0);

    do_set(48'd5, 32'd999_999_990);
    chk("set_sec", ptp_sec, 5);
    chk("set_ns", ptp_ns, 999_999_990);
    chk("set_pps", pps, 0);
    step_clk(1);
    chk("roll_sec", ptp_sec, 6);
    chk("roll_ns", ptp_ns, 10);
    chk("roll_pps", pps, 1);
    step_clk(1);
    chk("roll_pps_off", pps, 0);
    chk("roll_ns2", ptp_ns, 30);

    do_set(48'd7, 32'd1_200_000_000);
    chk("sat_ns", ptp_ns, 999_999_999);
    step_clk(1);
    chk("sat_roll_sec", ptp_sec, 8);
    chk("sat_roll_ns", ptp_ns, 19);

    rate_valid = 1'b1; rate_int = 8'd19; rate_frac = 32'h8000_0000;
    do_set(48'd0, 32'd0);
    rate_valid = 1'b0;
    chk("rate_load_ns", ptp_ns, 0);
    step_clk(1);
    chk("rate_d1", ptp_ns, 19);
    step_clk(1);
    chk("rate_d2", ptp_ns, 39);
    step_clk(998);
    chk("rate_1000", ptp_ns, 19500);
    chk("rate_sec", ptp_sec, 0);

    rate_valid = 1'b1; rate_int = 8'd20; rate_frac = 32'd0;
    do_set(48'd100, 32'd1000);
    rate_valid = 1'b0;
    do_adj(1'b1, 30'd10);
    chk("slew_start_ns", ptp_ns, 1020);
    chk("slew_start_busy", adj_busy, 1);
    prev_ns = ptp_ns;
    for (int i = 0; i < 4; i++) begin
      step_clk(1);
      chk($sformatf("slew_delta%0d", i), ptp_ns - prev_ns, slew_delta[i]);
      chk($sformatf("slew_busy%0d", i), adj_busy, slew_busy[i]);
      prev_ns = ptp_ns;
    end

    do_set(48'd3, 32'd1000);
    do_adj(1'b1, 30'd5_000_000);
    chk("stepb_sec", ptp_sec, 2);
    chk("stepb_ns", ptp_ns, 995_001_020);
    chk("stepb_pps", pps, 0);
    chk("stepb_busy", adj_busy, 0);

    do_set(48'd0, 32'd1000);
    do_adj(1'b1, 30'd5_000_000);
    chk("stepw_sec", ptp_sec, 48'hFFFF_FFFF_FFFF);
    chk("stepw_ns", ptp_ns, 995_001_020);

    do_set(48'd4, 32'd999_000_000);
    do_adj(1'b0, 30'd2_000_000);
    chk("stepf_sec", ptp_sec, 5);
    chk("stepf_ns", ptp_ns, 1_000_020);
    chk("stepf_pps", pps, 0);

    do_set(48'd9, 32'd500);
    do_adj(1'b1, 30'd100);
    chk("prio_pre_ns", ptp_ns, 520);
    step_clk(1);
    chk("prio_slew_ns", ptp_ns, 536);
    chk("prio_slew_busy", adj_busy, 1);
    adj_valid = 1'b1; adj_neg = 1'b1; adj_ns = 30'd50;
    rate_valid = 1'b1; rate_int = 8'd21; rate_frac = 32'd0;
    do_set(48'd20, 32'd40);
    adj_valid = 1'b0; rate_valid = 1'b0;
    chk("prio_sec", ptp_sec, 20);
    chk("prio_ns", ptp_ns, 40);
    chk("prio_busy", adj_busy, 0);
    chk("prio_pps", pps, 0);
    step_clk(1);
    chk("prio_rate_ns", ptp_ns, 61);
    chk("prio_busy2", adj_busy, 0);

    do_set(48'hFFFF_FFFF_FFFF, 32'd999_999_990);
    step_clk(1);
    chk("secwrap_sec", ptp_sec, 0);
    chk("secwrap_ns", ptp_ns, 11);
    chk("secwrap_pps", pps, 1);

    rate_valid = 1'b1; rate_int = 8'd0; rate_frac = 32'd0;
    step_clk(1);
    rate_valid = 1'b0;
    chk("freeze_last", ptp_ns, 32);
    step_clk(2);
    chk("freeze_ns", ptp_ns, 32);
    do_adj(1'b1, 30'd10);
    step_clk(3);
    chk("freeze_slew_ns", ptp_ns, 32);
    chk("freeze_slew_busy", adj_busy, 1);

    #3 rst_n = 1'b0;
    #1;
    chk("arst_sec", ptp_sec, 0);
    chk("arst_ns", ptp_ns, 0);
    chk("arst_busy", adj_busy, 0);
    chk("arst_pps", pps, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
